// File: rtl/triangle_bbox_scanner.sv
// Emits every pixel of a triangle's screen-clipped bounding box, LANES pixels per beat, row-major.
// Latency: start accepted at N, setup at N+1, first beat at N+2; o_done the cycle after the last transfer.
// Backpressure: the scan advances only on o_valid & i_ready; all beat outputs hold stable while stalled.
module triangle_bbox_scanner #(
  parameter int COORD_W   = 32,
  parameter int FRAC_BITS = 16,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int LANES     = 1,
  localparam int XW       = $clog2(SCREEN_W),
  localparam int YW       = $clog2(SCREEN_H)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [COORD_W-1:0] i_v1_x,
  input  logic [COORD_W-1:0] i_v1_y,
  input  logic [COORD_W-1:0] i_v2_x,
  input  logic [COORD_W-1:0] i_v2_y,
  input  logic [COORD_W-1:0] i_v3_x,
  input  logic [COORD_W-1:0] i_v3_y,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_ready,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XW-1:0]      o_x,
  output logic [YW-1:0]      o_y,
  output logic [LANES-1:0]   o_mask,
  output logic               o_last,
  output logic               o_done
);

  // Integer parts carry one extra bit so clip and emptiness comparisons never overflow.
  localparam int IW = COORD_W - FRAC_BITS + 1;
  localparam logic signed [IW-1:0] ZERO = '0;
  localparam logic signed [IW-1:0] X_HI = IW'(SCREEN_W - 1);
  localparam logic signed [IW-1:0] Y_HI = IW'(SCREEN_H - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;

  logic [1:0]                state;
  logic signed [COORD_W-1:0] v1x_r, v1y_r, v2x_r, v2y_r, v3x_r, v3y_r;
  logic [XW:0]               xmin_r, xmax_r, x_r;
  logic [YW-1:0]             ymin_r, ymax_r, y_r;
  logic                      done_r;

  // Floor of a fixed-point value: arithmetic shift on a sign-extended copy.
  function automatic logic signed [IW-1:0] int_part(input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W:0] ext;
    ext = $signed({c[COORD_W-1], c}) >>> FRAC_BITS;
    return IW'(ext);
  endfunction

  function automatic logic signed [IW-1:0] min3(input logic signed [IW-1:0] a, b, c);
    logic signed [IW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [IW-1:0] max3(input logic signed [IW-1:0] a, b, c);
    logic signed [IW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  logic signed [IW-1:0] bx_min, bx_max, by_min, by_max;
  logic signed [IW-1:0] cx_min, cx_max, cy_min, cy_max;
  logic                 box_empty;

  // Setup datapath: unclipped box, emptiness against the screen, then clip to the screen.
  always_comb begin
    bx_min    = min3(int_part(v1x_r), int_part(v2x_r), int_part(v3x_r));
    bx_max    = max3(int_part(v1x_r), int_part(v2x_r), int_part(v3x_r));
    by_min    = min3(int_part(v1y_r), int_part(v2y_r), int_part(v3y_r));
    by_max    = max3(int_part(v1y_r), int_part(v2y_r), int_part(v3y_r));
    box_empty = (bx_max < ZERO) || (bx_min > X_HI) || (by_max < ZERO) || (by_min > Y_HI);
    cx_min    = (bx_min < ZERO) ? ZERO : bx_min;
    cx_max    = (bx_max > X_HI) ? X_HI : bx_max;
    cy_min    = (by_min < ZERO) ? ZERO : by_min;
    cy_max    = (by_max > Y_HI) ? Y_HI : by_max;
  end

  logic        scan_vld;
  logic [XW:0] x_step;
  logic        x_end;

  // Beat decode: lane k is live while x+k stays inside the clipped right edge.
  always_comb begin
    scan_vld = (state == ST_SCAN);
    x_step   = x_r + (XW+1)'(LANES);
    x_end    = (x_step > xmax_r);
    o_mask   = '0;
    for (int k = 0; k < LANES; k++) begin
      o_mask[k] = scan_vld && ((x_r + (XW+1)'(k)) <= xmax_r);
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_valid = scan_vld;
  assign o_x     = scan_vld ? x_r[XW-1:0] : '0;
  assign o_y     = scan_vld ? y_r : '0;
  assign o_last  = scan_vld && x_end && (y_r == ymax_r);
  assign o_done  = done_r;

  // Control FSM: capture, setup, then walk the box one transfer at a time; abort wins over any step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      done_r <= 1'b0;
      v1x_r  <= '0;
      v1y_r  <= '0;
      v2x_r  <= '0;
      v2y_r  <= '0;
      v3x_r  <= '0;
      v3y_r  <= '0;
      xmin_r <= '0;
      xmax_r <= '0;
      ymin_r <= '0;
      ymax_r <= '0;
      x_r    <= '0;
      y_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            v1x_r <= i_v1_x;
            v1y_r <= i_v1_y;
            v2x_r <= i_v2_x;
            v2y_r <= i_v2_y;
            v3x_r <= i_v3_x;
            v3y_r <= i_v3_y;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (i_abort) begin
            state <= ST_IDLE;
          end else begin
            xmin_r <= (XW+1)'(cx_min);
            xmax_r <= (XW+1)'(cx_max);
            ymin_r <= YW'(cy_min);
            ymax_r <= YW'(cy_max);
            x_r    <= (XW+1)'(cx_min);
            y_r    <= YW'(cy_min);
            if (box_empty) begin
              state  <= ST_IDLE;
              done_r <= 1'b1;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (i_abort) begin
            state <= ST_IDLE;
          end else if (i_ready) begin
            if (!x_end) begin
              x_r <= x_step;
            end else if (y_r < ymax_r) begin
              x_r <= xmin_r;
              y_r <= y_r + 1'b1;
            end else begin
              state  <= ST_IDLE;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_bbox_scanner.sv
// Bench for triangle_bbox_scanner: LANES=1 and LANES=4 instances share stimulus.
// Expected beats come from a plain-arithmetic bounding-box model.
// Random i_ready exercises stalls; directed cases cover clip, empty box, abort and reset.
module tb_triangle_bbox_scanner;
  localparam int CW = 32;
  localparam int SW = 640;
  localparam int SH = 480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, rdy;
  logic [CW-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic       d1_ready, d1_valid, d1_last, d1_done;
  logic [9:0] d1_x;
  logic [8:0] d1_y;
  logic [0:0] d1_mask;
  logic       d4_ready, d4_valid, d4_last, d4_done;
  logic [9:0] d4_x;
  logic [8:0] d4_y;
  logic [3:0] d4_mask;

  triangle_bbox_scanner #(.COORD_W(CW), .FRAC_BITS(16), .SCREEN_W(SW), .SCREEN_H(SH), .LANES(1)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
    .i_start(start), .i_abort(abort), .o_ready(d1_ready), .o_valid(d1_valid), .i_ready(rdy),
    .o_x(d1_x), .o_y(d1_y), .o_mask(d1_mask), .o_last(d1_last), .o_done(d1_done));

  triangle_bbox_scanner #(.COORD_W(CW), .FRAC_BITS(16), .SCREEN_W(SW), .SCREEN_H(SH), .LANES(4)) dut4 (
    .i_clk(clk), .i_reset(rst),
    .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
    .i_start(start), .i_abort(abort), .o_ready(d4_ready), .o_valid(d4_valid), .i_ready(rdy),
    .o_x(d4_x), .o_y(d4_y), .o_mask(d4_mask), .o_last(d4_last), .o_done(d4_done));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int key(input int x, input int y, input int m, input int l);
    return x + (y << 10) + (m << 19) + (l << 27);
  endfunction

  function automatic int fx(input real r);
    return int'(r * 65536.0);
  endfunction

  function automatic int ipart(input int v);
    return int'($floor(real'(v) / 65536.0));
  endfunction

  // Reference: floor, min/max, empty test, clip, then row-major walk in LANES steps.
  task automatic model(input int v[6], input int lanes, output int q[$]);
    int xs[3], ys[3];
    int xmin, xmax, ymin, ymax, m;
    q = {};
    for (int i = 0; i < 3; i++) begin
      xs[i] = ipart(v[2*i]);
      ys[i] = ipart(v[2*i+1]);
    end
    xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < xmin) xmin = xs[i];
      if (xs[i] > xmax) xmax = xs[i];
      if (ys[i] < ymin) ymin = ys[i];
      if (ys[i] > ymax) ymax = ys[i];
    end
    if (xmax < 0 || xmin > SW-1 || ymax < 0 || ymin > SH-1) return;
    if (xmin < 0) xmin = 0;
    if (xmax > SW-1) xmax = SW-1;
    if (ymin < 0) ymin = 0;
    if (ymax > SH-1) ymax = SH-1;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x += lanes) begin
        m = 0;
        for (int k = 0; k < lanes; k++) if (x + k <= xmax) m |= (1 << k);
        q.push_back(key(x, y, m, int'((x + lanes > xmax) && (y == ymax))));
      end
    end
  endtask

  int  got0[$], got1[$];
  int  first_cyc[2], last_cyc[2], done_cyc[2], done_cnt[2], prev_key[2];
  bit  stalled[2];

  task automatic observe(input int id, input logic vld, input logic r, input logic [9:0] x,
                         input logic [8:0] y, input logic [7:0] m, input logic l, input logic d);
    int cur;
    cur = key(int'(x), int'(y), int'(m), int'(l));
    if (stalled[id]) chk($sformatf("stall_hold%0d", id), {31'd0, vld, cur}, {31'd0, 1'b1, prev_key[id]});
    if (!vld) chk($sformatf("zero_when_idle%0d", id), cur, 0);
    stalled[id]  = vld && !r;
    prev_key[id] = cur;
    if (vld && r) begin
      if (id == 0) got0.push_back(cur); else got1.push_back(cur);
      if (l) last_cyc[id] = cyc;
    end
    if (vld && first_cyc[id] < 0) first_cyc[id] = cyc;
    if (d) begin
      done_cnt[id]++;
      done_cyc[id] = cyc;
    end
  endtask

  // Outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      observe(0, d1_valid, rdy, d1_x, d1_y, {7'd0, d1_mask}, d1_last, d1_done);
      observe(1, d4_valid, rdy, d4_x, d4_y, {4'd0, d4_mask}, d4_last, d4_done);
    end
  end

  task automatic clear_trackers();
    got0 = {};
    got1 = {};
    for (int i = 0; i < 2; i++) begin
      first_cyc[i] = -1; last_cyc[i] = -1; done_cyc[i] = -1; done_cnt[i] = 0; stalled[i] = 1'b0;
    end
  endtask

  task automatic drive_v(input int v[6]);
    v1x = v[0]; v1y = v[1]; v2x = v[2]; v2y = v[3]; v3x = v[4]; v3y = v[5];
  endtask

  task automatic compare(input int id, input int e[$], input int s);
    int g[$];
    if (id == 0) g = got0; else g = got1;
    chk($sformatf("beat_count%0d", id), g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++) chk($sformatf("beat%0d_%0d", id, i), g[i], e[i]);
    chk($sformatf("done_count%0d", id), done_cnt[id], 1);
    if (e.size() > 0) begin
      chk($sformatf("first_latency%0d", id), first_cyc[id], s + 2);
      chk($sformatf("done_after_last%0d", id), done_cyc[id], last_cyc[id] + 1);
    end else begin
      chk($sformatf("no_valid%0d", id), first_cyc[id], -1);
      chk($sformatf("empty_done%0d", id), done_cyc[id], s + 2);
    end
  endtask

  // One triangle on both instances; waits (bounded) until both are idle again.
  task automatic run_tri(input int v[6], input int pct, input bit abort_too);
    int e1[$], e4[$];
    int s;
    bit fin;
    model(v, 1, e1);
    model(v, 4, e4);
    clear_trackers();
    drive_v(v);
    start = 1'b1;
    abort = abort_too;
    rdy   = ($urandom_range(99) < pct);
    s     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    fin   = 1'b0;
    for (int k = 0; k < 20000 && !fin; k++) begin
      rdy = ($urandom_range(99) < pct);
      @(posedge clk); #1;
      fin = d1_ready && d4_ready;
    end
    if (!fin) chk("timeout", 0, 1);
    @(negedge clk);
    @(posedge clk); #1;
    compare(0, e1, s);
    compare(1, e4, s);
  endtask

  // Kill a running triangle on its 3rd beat with abort or reset.
  task automatic kill_case(input int v[6], input bit use_reset);
    int e1[$];
    model(v, 1, e1);
    clear_trackers();
    drive_v(v);
    rdy   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    if (use_reset) rst = 1'b1; else abort = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    abort = 1'b0;
    chk("kill_valid1", d1_valid, 0);
    chk("kill_valid4", d4_valid, 0);
    chk("kill_ready1", d1_ready, 1);
    chk("kill_ready4", d4_ready, 1);
    chk("kill_done1", d1_done, 0);
    chk("kill_xy1", {d1_x, d1_y, d1_mask, d1_last}, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("kill_no_done1", done_cnt[0], 0);
    chk("kill_no_done4", done_cnt[1], 0);
    if (got0.size() >= 2) chk("kill_prefix1", got0[1], e1[1]);
    else chk("kill_prefix_len1", got0.size(), 2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=%0d exp=0", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int va[6], vb[6], vc[6], ve[6], vr[6];
    int cx, cy;
    rst = 1'b1; start = 1'b0; abort = 1'b0; rdy = 1'b0;
    v1x = '0; v1y = '0; v2x = '0; v2y = '0; v3x = '0; v3y = '0;
    clear_trackers();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready1", d1_ready, 1);
    chk("rst_ready4", d4_ready, 1);
    chk("rst_valid1", d1_valid, 0);
    chk("rst_outs1", {d1_x, d1_y, d1_mask, d1_last, d1_done}, 0);
    chk("rst_outs4", {d4_valid, d4_x, d4_y, d4_mask, d4_last, d4_done}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    va = '{fx(2.5), fx(1.0), fx(5.0), fx(1.75), fx(3.25), fx(3.0)};
    vb = '{fx(2.5), fx(1.0), fx(6.0), fx(1.75), fx(3.25), fx(3.0)};
    vc = '{fx(-3.5), fx(-2.0), fx(1.0), fx(0.5), fx(0.25), fx(1.25)};
    ve = '{fx(700.0), fx(10.0), fx(710.0), fx(20.0), fx(705.5), fx(30.0)};

    run_tri(va, 100, 1'b0);
    chk("a_len", got0.size(), 12);
    if (got0.size() == 12) begin
      chk("a_first", got0[0], key(2, 1, 1, 0));
      chk("a_last", got0[11], key(5, 3, 1, 1));
    end

    run_tri(vb, 100, 1'b0);
    chk("b_len4", got1.size(), 6);
    if (got1.size() == 6) begin
      chk("b_beat0", got1[0], key(2, 1, 15, 0));
      chk("b_beat1", got1[1], key(6, 1, 1, 0));
      chk("b_last", got1[5], key(6, 3, 1, 1));
    end

    run_tri(vc, 100, 1'b1);
    chk("c_len", got0.size(), 4);
    if (got0.size() == 4) chk("c_last", got0[3], key(1, 1, 1, 1));

    run_tri(ve, 100, 1'b0);
    chk("e_len", got0.size(), 0);

    run_tri(va, 50, 1'b0);
    chk("stall_len", got0.size(), 12);

    kill_case(va, 1'b0);
    run_tri(va, 100, 1'b0);
    kill_case(va, 1'b1);
    run_tri(va, 100, 1'b0);

    for (int t = 0; t < 20; t++) begin
      cx = int'($urandom_range(0, 700)) - 30;
      cy = int'($urandom_range(0, 540)) - 30;
      for (int i = 0; i < 3; i++) begin
        vr[2*i]   = (cx + int'($urandom_range(0, 24)) - 12) * 65536 + int'($urandom_range(0, 65535));
        vr[2*i+1] = (cy + int'($urandom_range(0, 24)) - 12) * 65536 + int'($urandom_range(0, 65535));
      end
      run_tri(vr, 70, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
